// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
//   - memType encodings as issued by the decode stage
//   - FSM state enum
//   - byte-enable helpers: size mask and lane-shifted 8-bit enable for a possible
//     two-word span (upper nibble = lanes spilled into the next word)
package load_store_unit_pkg;

   localparam logic [2:0] MemTypeB  = 3'b000;
   localparam logic [2:0] MemTypeH  = 3'b001;
   localparam logic [2:0] MemTypeW  = 3'b010;
   localparam logic [2:0] MemTypeBu = 3'b100;
   localparam logic [2:0] MemTypeHu = 3'b101;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWaitR
   } lsu_state_e;

   function automatic logic type_legal(input logic [2:0] mem_type);
      case (mem_type)
         MemTypeB, MemTypeH, MemTypeW, MemTypeBu, MemTypeHu: type_legal = 1'b1;
         default:                                            type_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] size_mask(input logic [2:0] mem_type);
      case (mem_type)
         MemTypeB, MemTypeBu: size_mask = 4'b0001;
         MemTypeH, MemTypeHu: size_mask = 4'b0011;
         MemTypeW:            size_mask = 4'b1111;
         default:             size_mask = 4'b0000;
      endcase
   endfunction

   // Bits [7:4] set means the access spills into the following word.
   function automatic logic [7:0] byte_enables(input logic [2:0] mem_type,
                                               input logic [1:0] offset);
      byte_enables = {4'b0000, size_mask(mem_type)} << offset;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load data alignment.
//   offset   : byte offset of the access within the first word
//   mem_type : access type (B/H/W/BU/HU)
//   word0    : first (lower-address) read word
//   word1    : second read word; only contributes when the access spans words
//   result   : extracted bytes, sign- or zero-extended to 32 bits
module lsu_load_align
   import load_store_unit_pkg::*;
(
   input  logic [1:0]  offset,
   input  logic [2:0]  mem_type,
   input  logic [31:0] word0,
   input  logic [31:0] word1,
   output logic [31:0] result
);

   logic [31:0] shifted;

   always_comb begin
      // Concatenating the two words lets split bytes fall into place with one shift.
      shifted = 32'({word1, word0} >> {offset, 3'b000});
      case (mem_type)
         MemTypeB:  result = {{24{shifted[7]}}, shifted[7:0]};
         MemTypeH:  result = {{16{shifted[15]}}, shifted[15:0]};
         MemTypeBu: result = {24'h000000, shifted[7:0]};
         MemTypeHu: result = {16'h0000, shifted[15:0]};
         default:   result = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the pipeline and a simple req/gnt/rvalid memory bus.
//   Pipeline side: memRead/memWrite/memAddr/memType/storeData in; stall, loadResult,
//                  loadValid, accessErr out.
//   Bus side:      mem_req/mem_we/mem_addr/mem_be/mem_wdata out; mem_gnt/mem_rvalid/
//                  mem_rdata in. One transaction outstanding at a time.
//   SPLIT_EN=1 splits word-spanning accesses into two bus accesses; SPLIT_EN=0
//   reports any misaligned access as an error without bus traffic.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter bit SPLIT_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [31:0] memAddr,
   input  logic [2:0]  memType,
   input  logic [31:0] storeData,
   output logic        stall,
   output logic [31:0] loadResult,
   output logic        loadValid,
   output logic        accessErr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   lsu_state_e  state_q, state_d;
   logic        phase_q, phase_d;   // 1 = second word of a split access
   logic        done_q, done_d;     // completion cycle; request still on the inputs
   logic        store_q, store_d;
   logic        split_q, split_d;
   logic [2:0]  type_q, type_d;
   logic [1:0]  off_q, off_d;
   logic [29:0] waddr_q, waddr_d;
   logic [7:0]  be_q, be_d;
   logic [63:0] wdata_q, wdata_d;
   logic [31:0] word0_q, word0_d;
   logic [31:0] result_q, result_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;

   logic        one_req, misaligned, allowed, idle_free, accept;
   logic [7:0]  req_be;
   logic [31:0] align_word0, align_result;

   always_comb begin
      one_req = memRead ^ memWrite;
      req_be  = byte_enables(memType, memAddr[1:0]);
      case (memType[1:0])
         2'b01:   misaligned = memAddr[0];
         2'b10:   misaligned = |memAddr[1:0];
         default: misaligned = 1'b0;
      endcase
      allowed   = one_req & type_legal(memType) & (SPLIT_EN | ~misaligned);
      // rst_n gating keeps stall low while reset is held with a request present.
      idle_free = (state_q == StIdle) & ~phase_q & ~done_q & rst_n;
      accept    = idle_free & allowed;
   end

   assign align_word0 = phase_q ? word0_q : mem_rdata;

   lsu_load_align u_load_align (
      .offset   (off_q),
      .mem_type (type_q),
      .word0    (align_word0),
      .word1    (mem_rdata),
      .result   (align_result)
   );

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      done_d   = 1'b0;
      store_d  = store_q;
      split_d  = split_q;
      type_d   = type_q;
      off_d    = off_q;
      waddr_d  = waddr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      word0_d  = word0_q;
      result_d = result_q;
      valid_d  = 1'b0;
      err_d    = idle_free & (memRead | memWrite) & ~allowed;

      case (state_q)
         StIdle: begin
            if (phase_q) begin
               // Second half of a split access re-enters through IDLE.
               state_d = StIssue;
            end else if (accept) begin
               store_d = memWrite;
               type_d  = memType;
               off_d   = memAddr[1:0];
               waddr_d = memAddr[31:2];
               be_d    = req_be;
               wdata_d = {32'h0, storeData} << {memAddr[1:0], 3'b000};
               split_d = |req_be[7:4];
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (mem_gnt) begin
               if (!store_q) begin
                  state_d = StWaitR;
               end else if (split_q && !phase_q) begin
                  phase_d = 1'b1;
                  state_d = StIdle;
               end else begin
                  phase_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         StWaitR: begin
            if (mem_rvalid) begin
               if (split_q && !phase_q) begin
                  word0_d = mem_rdata;
                  phase_d = 1'b1;
                  state_d = StIdle;
               end else begin
                  result_d = align_result;
                  valid_d  = 1'b1;
                  done_d   = 1'b1;
                  phase_d  = 1'b0;
                  state_d  = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         phase_q  <= 1'b0;
         done_q   <= 1'b0;
         store_q  <= 1'b0;
         split_q  <= 1'b0;
         type_q   <= 3'b000;
         off_q    <= 2'b00;
         waddr_q  <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         word0_q  <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         done_q   <= done_d;
         store_q  <= store_d;
         split_q  <= split_d;
         type_q   <= type_d;
         off_q    <= off_d;
         waddr_q  <= waddr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         word0_q  <= word0_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      mem_req    = (state_q == StIssue);
      mem_we     = mem_req & store_q;
      mem_addr   = mem_req ? {waddr_q + {29'h0, phase_q}, 2'b00} : '0;
      mem_be     = mem_req ? (phase_q ? be_q[7:4] : be_q[3:0]) : '0;
      mem_wdata  = mem_req ? (phase_q ? wdata_q[63:32] : wdata_q[31:0]) : '0;
      stall      = (state_q != StIdle) | phase_q | accept;
      loadResult = result_q;
      loadValid  = valid_q;
      accessErr  = err_q;
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        clk, rst_n;
   logic        memRead, memWrite, ns_memRead, ns_memWrite;
   logic [31:0] memAddr, storeData;
   logic [2:0]  memType;
   logic        stall, loadValid, accessErr, mem_req, mem_we;
   logic [31:0] loadResult, mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        mem_gnt, mem_rvalid;
   logic        ns_stall, ns_loadValid, ns_accessErr, ns_mem_req, ns_mem_we;
   logic [31:0] ns_loadResult, ns_mem_addr, ns_mem_wdata;
   logic [3:0]  ns_mem_be;
   logic        ns_gnt, ns_rvalid;
   logic [31:0] ns_rdata;

   int n_checks, n_fail;
   logic [7:0]  bus_mem [0:1023];
   logic [7:0]  ref_mem [0:1023];
   logic [31:0] cap_addr [2];
   logic [31:0] cap_wdata [2];
   logic [3:0]  cap_be [2];
   int          last_stalls;
   logic [31:0] last_result;

   load_store_unit #(.SPLIT_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite), .memAddr(memAddr),
      .memType(memType), .storeData(storeData), .stall(stall), .loadResult(loadResult),
      .loadValid(loadValid), .accessErr(accessErr), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   load_store_unit #(.SPLIT_EN(1'b0)) dut_ns (
      .clk(clk), .rst_n(rst_n), .memRead(ns_memRead), .memWrite(ns_memWrite),
      .memAddr(memAddr), .memType(memType), .storeData(storeData), .stall(ns_stall),
      .loadResult(ns_loadResult), .loadValid(ns_loadValid), .accessErr(ns_accessErr),
      .mem_req(ns_mem_req), .mem_we(ns_mem_we), .mem_addr(ns_mem_addr), .mem_be(ns_mem_be),
      .mem_wdata(ns_mem_wdata), .mem_gnt(ns_gnt), .mem_rvalid(ns_rvalid), .mem_rdata(ns_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int size_of(input logic [2:0] t);
      case (t[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   // Reference load: gather bytes little-endian from the model memory, then extend.
   function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] t);
      logic [31:0] v;
      v = 32'h0;
      for (int k = 0; k < size_of(t); k++) v[8*k +: 8] = ref_mem[int'(addr[9:0]) + k];
      if (t == 3'b000 && v[7])  v[31:8]  = '1;
      if (t == 3'b001 && v[15]) v[31:16] = '1;
      return v;
   endfunction

   task automatic set_word(input int a, input logic [31:0] w);
      for (int k = 0; k < 4; k++) begin
         bus_mem[a + k] = w[8*k +: 8];
         ref_mem[a + k] = w[8*k +: 8];
      end
   endtask

   // One legal access; acts as bus responder with gw grant and rw rvalid wait states.
   task automatic do_access(input logic rd, input logic [2:0] t, input logic [31:0] addr,
                            input logic [31:0] data, input int gw, input int rw);
      int nph, exp_stalls, stalls, gcnt, rcnt, lv_count, ph, ra;
      logic rd_pend, held, done;
      logic [31:0] rd_addr, sv_addr, sv_wdata;
      logic [3:0] sv_be;
      logic sv_we;
      nph = (int'(addr[1:0]) + size_of(t) > 4) ? 2 : 1;
      exp_stalls = nph * ((rd ? 3 : 2) + gw + (rd ? rw : 0));
      stalls = 0; gcnt = 0; rcnt = 0; lv_count = 0; ph = 0;
      rd_pend = 0; held = 0; done = 0; rd_addr = 0;
      sv_addr = 0; sv_wdata = 0; sv_be = 0; sv_we = 0;
      last_result = 32'h0;
      @(posedge clk); #1;
      memRead = rd; memWrite = !rd; memAddr = addr; memType = t; storeData = data;
      for (int cyc = 0; cyc < 200; cyc++) begin
         mem_rvalid = 1'b0;
         if (rd_pend) begin
            if (rcnt >= rw) begin
               ra = int'(rd_addr[9:0]);
               mem_rvalid = 1'b1;
               mem_rdata = {bus_mem[ra + 3], bus_mem[ra + 2], bus_mem[ra + 1], bus_mem[ra]};
               rd_pend = 0;
            end else rcnt++;
         end
         mem_gnt = 1'b0;
         if (held) begin
            check_val("req_held", 32'(mem_req), 32'd1);
            check_val("addr_stable", mem_addr, sv_addr);
            check_val("be_stable", 32'(mem_be), 32'(sv_be));
            check_val("wdata_stable", mem_wdata, sv_wdata);
            check_val("we_stable", 32'(mem_we), 32'(sv_we));
         end
         if (mem_req) begin
            sv_addr = mem_addr; sv_be = mem_be; sv_wdata = mem_wdata; sv_we = mem_we;
            if (gcnt >= gw) begin
               mem_gnt = 1'b1;
               if (ph < 2) begin
                  cap_addr[ph] = mem_addr; cap_be[ph] = mem_be; cap_wdata[ph] = mem_wdata;
               end
               ph++;
               if (mem_we) begin
                  for (int k = 0; k < 4; k++)
                     if (mem_be[k]) bus_mem[int'(mem_addr[9:0]) + k] = mem_wdata[8*k +: 8];
               end else begin
                  rd_pend = 1; rd_addr = mem_addr; rcnt = 0;
               end
               gcnt = 0;
            end else gcnt++;
         end
         held = mem_req && !mem_gnt;
         #1;
         if (loadValid) begin lv_count++; last_result = loadResult; end
         if (!stall) begin done = 1; break; end
         stalls++;
         @(posedge clk); #1;
      end
      if (!done) check_val("timeout", 32'd0, 32'd1);
      last_stalls = stalls;
      check_val("stall_cycles", 32'(stalls), 32'(exp_stalls));
      check_val("bus_phases", 32'(ph), 32'(nph));
      check_val("load_valid_count", 32'(lv_count), rd ? 32'd1 : 32'd0);
      if (rd) begin
         check_val("load_result", last_result, ref_load(addr, t));
      end else begin
         for (int k = 0; k < size_of(t); k++) ref_mem[int'(addr[9:0]) + k] = data[8*k +: 8];
         for (int k = 0; k < 8; k++) begin
            ra = int'({addr[9:2], 2'b00}) + k;
            check_val("store_bytes", 32'(bus_mem[ra]), 32'(ref_mem[ra]));
         end
      end
      @(posedge clk); #1;
      memRead = 1'b0; memWrite = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      #1;
      check_val("no_reaccept", 32'(mem_req), 32'd0);
      check_val("valid_pulse", 32'(loadValid), 32'd0);
   endtask

   // Request that must be rejected with an accessErr pulse and no bus traffic.
   task automatic do_error(input logic use_ns, input logic rd, input logic wr,
                           input logic [2:0] t, input logic [31:0] addr);
      @(posedge clk); #1;
      memAddr = addr; memType = t;
      if (use_ns) begin ns_memRead = rd; ns_memWrite = wr; end
      else begin memRead = rd; memWrite = wr; end
      #1;
      check_val("err_stall", 32'(use_ns ? ns_stall : stall), 32'd0);
      @(posedge clk); #1;
      memRead = 0; memWrite = 0; ns_memRead = 0; ns_memWrite = 0;
      #1;
      check_val("err_pulse", 32'(use_ns ? ns_accessErr : accessErr), 32'd1);
      check_val("err_no_req", 32'(use_ns ? ns_mem_req : mem_req), 32'd0);
      @(posedge clk); #2;
      check_val("err_pulse_end", 32'(use_ns ? ns_accessErr : accessErr), 32'd0);
      check_val("err_no_req2", 32'(use_ns ? ns_mem_req : mem_req), 32'd0);
   endtask

   initial begin
      logic [2:0] ld_types [5];
      logic [2:0] t;
      logic rd;
      ld_types[0] = 3'b000; ld_types[1] = 3'b001; ld_types[2] = 3'b010;
      ld_types[3] = 3'b100; ld_types[4] = 3'b101;
      n_checks = 0; n_fail = 0;
      rst_n = 1'b0;
      memRead = 0; memWrite = 0; ns_memRead = 0; ns_memWrite = 0;
      memAddr = 0; memType = 0; storeData = 0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
      ns_gnt = 0; ns_rvalid = 0; ns_rdata = 0;
      for (int i = 0; i < 1024; i++) begin
         bus_mem[i] = 8'($urandom);
         ref_mem[i] = bus_mem[i];
      end
      repeat (2) @(posedge clk);
      #1;
      check_val("reset_stall", 32'(stall), 32'd0);
      check_val("reset_req", 32'(mem_req), 32'd0);
      check_val("reset_result", loadResult, 32'd0);
      rst_n = 1'b1;

      do_access(1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0);
      check_val("sw_addr", cap_addr[0], 32'h100);
      check_val("sw_be", 32'(cap_be[0]), 32'hF);
      check_val("sw_wdata", cap_wdata[0], 32'hDEADBEEF);
      check_val("sw_stall2", 32'(last_stalls), 32'd2);

      set_word(32'h200, 32'h80FFFFFF);
      do_access(1'b1, 3'b000, 32'h203, 32'h0, 0, 0);
      check_val("lb_result", last_result, 32'hFFFFFF80);
      do_access(1'b1, 3'b100, 32'h203, 32'h0, 0, 0);
      check_val("lbu_result", last_result, 32'h00000080);

      set_word(32'h300, 32'h44332211);
      set_word(32'h304, 32'h88776655);
      do_access(1'b1, 3'b010, 32'h302, 32'h0, 0, 0);
      check_val("split_be0", 32'(cap_be[0]), 32'hC);
      check_val("split_be1", 32'(cap_be[1]), 32'h3);
      check_val("split_addr0", cap_addr[0], 32'h300);
      check_val("split_addr1", cap_addr[1], 32'h304);
      check_val("split_result", last_result, 32'h66554433);

      do_access(1'b0, 3'b001, 32'h10, 32'h0000ABCD, 3, 0);
      check_val("sh_be", 32'(cap_be[0]), 32'h3);
      check_val("sh_wdata", cap_wdata[0] & 32'h0000FFFF, 32'h0000ABCD);

      do_error(1'b0, 1'b1, 1'b1, 3'b010, 32'h100);
      do_error(1'b0, 1'b1, 1'b0, 3'b011, 32'h100);
      do_error(1'b1, 1'b1, 1'b0, 3'b010, 32'h2);

      // Reset while a load waits for read data.
      @(posedge clk); #1;
      memRead = 1; memWrite = 0; memType = 3'b010; memAddr = 32'h40;
      @(posedge clk); #1;
      mem_gnt = 1;
      #1 check_val("rst_pre_req", 32'(mem_req), 32'd1);
      @(posedge clk); #1;
      mem_gnt = 0;
      #1 check_val("rst_pre_stall", 32'(stall), 32'd1);
      rst_n = 1'b0;
      #1;
      check_val("rst_stall", 32'(stall), 32'd0);
      check_val("rst_req", 32'(mem_req), 32'd0);
      check_val("rst_be", 32'(mem_be), 32'd0);
      check_val("rst_addr", mem_addr, 32'd0);
      check_val("rst_valid", 32'(loadValid), 32'd0);
      check_val("rst_err", 32'(accessErr), 32'd0);
      @(posedge clk); #1;
      memRead = 0; mem_rvalid = 1; mem_rdata = 32'h12345678;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      mem_rvalid = 0;
      #1;
      check_val("rst_late_valid", 32'(loadValid), 32'd0);
      check_val("rst_late_req", 32'(mem_req), 32'd0);
      check_val("rst_late_stall", 32'(stall), 32'd0);
      do_access(1'b1, 3'b010, 32'h40, 32'h0, 0, 0);

      for (int i = 0; i < 60; i++) begin
         rd = 1'($urandom);
         t = rd ? ld_types[$urandom_range(0, 4)] : ld_types[$urandom_range(0, 2)];
         do_access(rd, t, 32'($urandom_range(0, 1015)), $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 2));
         if (i % 10 == 0) do_error(1'b0, 1'b1, 1'b0, 3'($urandom_range(6, 7)), 32'h80);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
